// File: rtl/dcache_responder.sv
// Direct-mapped, one-word-per-line, write-through, no-write-allocate data cache
// serving the MEM stage, with a single outstanding req/ack transaction to backing memory.
module dcache_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memread_M,
    input  logic                  memwrite,
    input  logic [2:0]            load_store_M,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] read_data2,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  miss,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int LINES    = 1 << IDX_BITS;
    localparam int TAG_BITS = DATA_WIDTH - IDX_BITS - 2;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t state, next_state;

    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];

    logic [IDX_BITS-1:0]   idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit;
    logic [DATA_WIDTH-1:0] line;

    logic [IDX_BITS-1:0]   req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  req_hit;

    logic                  start_fill;
    logic                  start_write;
    logic [3:0]            st_wstrb;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_ext;

    assign idx  = alu_result[IDX_BITS+1:2];
    assign tag  = alu_result[DATA_WIDTH-1:IDX_BITS+2];
    assign hit  = valid_q[idx] && (tag_q[idx] == tag);
    assign line = data_q[idx];

    // Completion-time lookups use the registered request address, which is the
    // address the backing memory actually served.
    assign req_idx = mem_addr[IDX_BITS+1:2];
    assign req_tag = mem_addr[DATA_WIDTH-1:IDX_BITS+2];
    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = read_data2;
        case (load_store_M[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << alu_result[1:0];
                st_wdata = {4{read_data2[7:0]}};
            end
            2'b01: begin
                st_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{read_data2[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = read_data2;
            end
        endcase
    end

    always_comb begin
        ld_byte = line[{alu_result[1:0], 3'b000} +: 8];
        ld_half = alu_result[1] ? line[31:16] : line[15:0];
        case (load_store_M)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = line;
        endcase
    end

    assign readdata = (memread_M && !memwrite && hit) ? ld_ext : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Miss is forced low while reset is held so an abandoned transaction
    // cannot keep the core stalled.
    always_comb begin
        next_state  = state;
        start_fill  = 1'b0;
        start_write = 1'b0;
        miss        = 1'b0;
        case (state)
            IDLE: begin
                if (memwrite) begin
                    next_state  = WRITE;
                    start_write = 1'b1;
                    miss        = 1'b1;
                end else if (memread_M && !hit) begin
                    next_state = FILL;
                    start_fill = 1'b1;
                    miss       = 1'b1;
                end
            end
            FILL: begin
                miss = 1'b1;
                if (mem_ack) next_state = IDLE;
            end
            WRITE: begin
                miss = 1'b1;
                if (mem_ack) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (!rst) miss = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
        end else if (start_fill) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {alu_result[DATA_WIDTH-1:2], 2'b00};
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
        end else if (start_write) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {alu_result[DATA_WIDTH-1:2], 2'b00};
            mem_wdata <= st_wdata;
            mem_wstrb <= st_wstrb;
        end else if ((state == FILL || state == WRITE) && mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (state == FILL && mem_ack) begin
            valid_q[req_idx] <= 1'b1;
        end
    end

    // A store miss leaves the line untouched; only a hit merges the strobed bytes.
    always_ff @(posedge clk) begin
        if (state == FILL && mem_ack) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= mem_rdata;
        end else if (state == WRITE && mem_ack && req_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) data_q[req_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: table-driven load-hit vectors plus
// hand-written fill, store, eviction and reset-abort sequences.
module tb_dcache_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        memread_M;
    logic        memwrite;
    logic [2:0]  load_store_M;
    logic [31:0] alu_result;
    logic [31:0] read_data2;
    logic [31:0] readdata;
    logic        miss;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rd2;
        logic [31:0] exp_data;
        logic        exp_miss;
    } vec_t;

    vec_t vecs[12];

    dcache_responder #(.DATA_WIDTH(32), .IDX_BITS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .memread_M    (memread_M),
        .memwrite     (memwrite),
        .load_store_M (load_store_M),
        .alu_result   (alu_result),
        .read_data2   (read_data2),
        .readdata     (readdata),
        .miss         (miss),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] rd2);
        @(posedge clk);
        #1;
        memread_M    = rd;
        memwrite     = wr;
        load_store_M = f3;
        alu_result   = addr;
        read_data2   = rd2;
    endtask

    // Plays the backing memory for one transaction, starting at the IDLE decision
    // cycle, and returns at the first cycle where miss is low again.
    task automatic run_txn(input string name, input int ack_delay, input logic [31:0] rdata,
                           input logic exp_we, input logic [31:0] exp_addr,
                           input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata);
        int miss_cnt = 0;
        int req_cnt  = 0;
        bit finished = 0;
        for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
            @(negedge clk);
            if (!miss) begin
                finished = 1;
            end else begin
                miss_cnt++;
                if (mem_req) begin
                    req_cnt++;
                    if (req_cnt == 1) begin
                        check_output({name, " mem_we"},    {31'd0, mem_we}, {31'd0, exp_we});
                        check_output({name, " mem_addr"},  mem_addr, exp_addr);
                        check_output({name, " mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
                        check_output({name, " mem_wdata"}, mem_wdata, exp_wdata);
                    end
                    if (req_cnt == ack_delay + 1) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rdata;
                        @(posedge clk);
                        #1;
                        mem_ack   = 1'b0;
                        mem_rdata = 32'd0;
                    end
                end
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: miss still high after 60 cycles", name);
        end
        check_output({name, " miss cycles"}, miss_cnt, ack_delay + 2);
        check_output({name, " req cycles"},  req_cnt,  ack_delay + 1);
        check_output({name, " req dropped"}, {31'd0, mem_req}, 32'd0);
    endtask

    task automatic check_hit(input string name, input logic [31:0] exp_data);
        @(negedge clk);
        check_output({name, " miss"}, {31'd0, miss}, 32'd0);
        check_output({name, " readdata"}, readdata, exp_data);
    endtask

    initial begin
        memread_M    = 1'b1;
        memwrite     = 1'b0;
        load_store_M = F_W;
        alu_result   = 32'h100;
        read_data2   = 32'd0;
        mem_ack      = 1'b0;
        mem_rdata    = 32'd0;
        rst          = 1'b1;
        #2 rst = 1'b0;
        #10;
        check_output("reset mem_req",   {31'd0, mem_req}, 32'd0);
        check_output("reset mem_we",    {31'd0, mem_we}, 32'd0);
        check_output("reset mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check_output("reset mem_addr",  mem_addr, 32'd0);
        check_output("reset mem_wdata", mem_wdata, 32'd0);
        check_output("reset miss",      {31'd0, miss}, 32'd0);
        check_output("reset readdata",  readdata, 32'd0);
        memread_M = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Cold load miss with ack on the fourth request cycle.
        apply_stimulus(1'b1, 1'b0, F_W, 32'h100, 32'd0);
        run_txn("T1 fill", 3, 32'hDEADBEEF, 1'b0, 32'h100, 4'b0000, 32'd0);
        check_output("T1 readdata", readdata, 32'hDEADBEEF);

        vecs[0]  = '{1'b1, 1'b0, F_W,  32'h100, 32'd0, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, F_B,  32'h103, 32'd0, 32'hFFFFFFDE, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, F_BU, 32'h103, 32'd0, 32'h000000DE, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, F_H,  32'h100, 32'd0, 32'hFFFFBEEF, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, F_HU, 32'h102, 32'd0, 32'h0000DEAD, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, F_H,  32'h102, 32'd0, 32'hFFFFDEAD, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, F_B,  32'h101, 32'd0, 32'hFFFFFFBE, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, F_BU, 32'h100, 32'd0, 32'h000000EF, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, F_HU, 32'h101, 32'd0, 32'h0000BEEF, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, F_W,  32'h103, 32'd0, 32'hDEADBEEF, 1'b0};
        vecs[10] = '{1'b0, 1'b0, F_W,  32'h100, 32'd0, 32'h00000000, 1'b0};
        vecs[11] = '{1'b1, 1'b0, F_B,  32'h102, 32'd0, 32'hFFFFFFAD, 1'b0};

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].rd2);
            @(negedge clk);
            check_output($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_data);
            check_output($sformatf("vec%0d miss", i), {31'd0, miss}, {31'd0, vecs[i].exp_miss});
        end

        // Store-byte hit: write-through, merge into line, one DONE cycle.
        apply_stimulus(1'b0, 1'b1, F_B, 32'h101, 32'h00000055);
        run_txn("T3 sb", 2, 32'd0, 1'b1, 32'h100, 4'b0010, 32'h55555555);
        apply_stimulus(1'b1, 1'b0, F_W, 32'h100, 32'd0);
        check_hit("T3 lw", 32'hDEAD55EF);

        // Same index, new tag: fill evicts, then the old address misses again.
        apply_stimulus(1'b1, 1'b0, F_W, 32'h140, 32'd0);
        run_txn("T5 fill 140", 0, 32'hCAFEF00D, 1'b0, 32'h140, 4'b0000, 32'd0);
        check_output("T5 readdata 140", readdata, 32'hCAFEF00D);
        apply_stimulus(1'b1, 1'b0, F_W, 32'h100, 32'd0);
        run_txn("T5 refill 100", 1, 32'hDEAD55EF, 1'b0, 32'h100, 4'b0000, 32'd0);
        check_output("T5 readdata 100", readdata, 32'hDEAD55EF);

        // Store-word miss: written through, cached line at that index untouched.
        apply_stimulus(1'b0, 1'b1, F_W, 32'h200, 32'h12345678);
        run_txn("T4 sw", 1, 32'd0, 1'b1, 32'h200, 4'b1111, 32'h12345678);
        apply_stimulus(1'b1, 1'b0, F_W, 32'h100, 32'd0);
        check_hit("T4 lw 100", 32'hDEAD55EF);
        apply_stimulus(1'b1, 1'b0, F_W, 32'h200, 32'd0);
        run_txn("T4 fill 200", 1, 32'h12345678, 1'b0, 32'h200, 4'b0000, 32'd0);
        check_output("T4 readdata 200", readdata, 32'h12345678);

        // Upper-half store hit on the freshly filled line.
        apply_stimulus(1'b0, 1'b1, F_H, 32'h202, 32'hFFFFABCD);
        run_txn("sh", 0, 32'd0, 1'b1, 32'h200, 4'b1100, 32'hABCDABCD);
        apply_stimulus(1'b1, 1'b0, F_W, 32'h200, 32'd0);
        check_hit("sh lw", 32'hABCD5678);

        // Stray ack while idle must be ignored.
        apply_stimulus(1'b0, 1'b0, F_W, 32'h200, 32'd0);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        @(negedge clk);
        check_output("idle ack miss",    {31'd0, miss}, 32'd0);
        check_output("idle ack mem_req", {31'd0, mem_req}, 32'd0);
        apply_stimulus(1'b1, 1'b0, F_W, 32'h200, 32'd0);
        check_hit("idle ack lw", 32'hABCD5678);

        // Reset in the middle of a fill abandons it and invalidates the cache.
        apply_stimulus(1'b1, 1'b0, F_W, 32'h300, 32'd0);
        begin
            bit seen = 0;
            for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
                @(negedge clk);
                if (mem_req) seen = 1;
            end
            check_output("T6 fill started", {31'd0, mem_req}, 32'd1);
        end
        rst = 1'b0;
        #1;
        check_output("T6 rst mem_req",  {31'd0, mem_req}, 32'd0);
        check_output("T6 rst miss",     {31'd0, miss}, 32'd0);
        check_output("T6 rst mem_addr", mem_addr, 32'd0);
        check_output("T6 rst mem_we",   {31'd0, mem_we}, 32'd0);
        memread_M = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b0, F_W, 32'h100, 32'd0);
        run_txn("T6 refill 100", 2, 32'h0BADF00D, 1'b0, 32'h100, 4'b0000, 32'd0);
        check_output("T6 readdata", readdata, 32'h0BADF00D);

        apply_stimulus(1'b0, 1'b0, F_W, 32'd0, 32'd0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
